reg_file_bus_target: RTL and testbench

- Terminal target stage downstream of the flattened addr/data/resp bus pass-through; consumes side_b of that block.
- Implements a small 8-bit register file behind five ready/valid channels:
  - addr_read and data_read for reads;
  - addr_write, data_write and resp_write for writes.
- Pairs write address and write data, commits the write, then returns a response code.
- Serves reads with one-cycle latency.

---
 rtl/reg_file_bus_target_pkg.sv | 22 ++
 rtl/reg_file_bus_target_array.sv | 30 +++
 rtl/reg_file_bus_target.sv | 141 ++++++++++++++
 tb/tb_reg_file_bus_target.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_bus_target_pkg.sv
// Shared definitions for the register-file bus target: response codes,
// the bus channel triple and the index-width helper.
package reg_file_bus_target_pkg;

    localparam logic [7:0] RESP_OKAY   = 8'h00;
    localparam logic [7:0] RESP_DECERR = 8'h02;

    typedef struct packed {
        logic [7:0] data;
        logic       valid;
        logic       ready;
    } bus_chan_t;

    // Bits needed to index `value` entries (never less than 1).
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned width;
        width = 0;
        while ((32'd1 << width) < value) width++;
        return (width == 0) ? 1 : width;
    endfunction

endpackage

// File: rtl/reg_file_bus_target_array.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one combinational
// read port and a synchronous clear of every entry.
module reg_file_array #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned IDX_W      = 4
) (
    input  logic                  clk_i,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [IDX_W-1:0]      waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [IDX_W-1:0]      raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    // Clear wins over write so nothing lands in the array on a reset edge.
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            mem_q <= '{default: '0};
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/reg_file_bus_target.sv
// Register-file bus target: pairs write address/data into holding registers,
// commits them and returns a response; serves reads with one-cycle latency.
module reg_file_bus_target
    import reg_file_bus_target_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] bus_addr_read_bus_data,
    input  logic                  bus_addr_read_bus_valid,
    output logic                  bus_addr_read_bus_ready,
    output logic [DATA_WIDTH-1:0] bus_data_read_bus_data,
    output logic                  bus_data_read_bus_valid,
    input  logic                  bus_data_read_bus_ready,
    input  logic [ADDR_WIDTH-1:0] bus_addr_write_bus_data,
    input  logic                  bus_addr_write_bus_valid,
    output logic                  bus_addr_write_bus_ready,
    input  logic [DATA_WIDTH-1:0] bus_data_write_bus_data,
    input  logic                  bus_data_write_bus_valid,
    output logic                  bus_data_write_bus_ready,
    output logic [DATA_WIDTH-1:0] bus_resp_write_bus_data,
    output logic                  bus_resp_write_bus_valid,
    input  logic                  bus_resp_write_bus_ready
);

    localparam int unsigned IDX_W = clog2(DEPTH);

    logic                  aw_full_q, aw_full_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_full_q, w_full_d;
    logic [DATA_WIDTH-1:0] w_data_q, w_data_d;
    logic                  rd_valid_q, rd_valid_d;
    logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                  resp_valid_q, resp_valid_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

    logic                  ar_fire, aw_fire, w_fire, commit;
    logic                  rd_in_range, wr_in_range;
    logic [DATA_WIDTH-1:0] arr_rdata;

    // Readies come from registered state (and the downstream ready), gated by reset.
    assign bus_addr_read_bus_ready  = !rst && (!rd_valid_q || bus_data_read_bus_ready);
    assign bus_addr_write_bus_ready = !rst && !aw_full_q;
    assign bus_data_write_bus_ready = !rst && !w_full_q;

    assign bus_data_read_bus_data   = rd_data_q;
    assign bus_data_read_bus_valid  = rd_valid_q;
    assign bus_resp_write_bus_data  = resp_data_q;
    assign bus_resp_write_bus_valid = resp_valid_q;

    assign ar_fire = bus_addr_read_bus_valid  && bus_addr_read_bus_ready;
    assign aw_fire = bus_addr_write_bus_valid && bus_addr_write_bus_ready;
    assign w_fire  = bus_data_write_bus_valid && bus_data_write_bus_ready;
    assign commit  = !rst && aw_full_q && w_full_q
                     && (!resp_valid_q || bus_resp_write_bus_ready);

    // DEPTH is a power of two, so in range means no bits above the index.
    assign rd_in_range = ((bus_addr_read_bus_data >> IDX_W) == '0);
    assign wr_in_range = ((aw_addr_q >> IDX_W) == '0);

    reg_file_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IDX_W      (IDX_W)
    ) u_array (
        .clk_i   (clk),
        .clr_i   (rst),
        .we_i    (commit && wr_in_range),
        .waddr_i (aw_addr_q[IDX_W-1:0]),
        .wdata_i (w_data_q),
        .raddr_i (bus_addr_read_bus_data[IDX_W-1:0]),
        .rdata_o (arr_rdata)
    );

    // Next-state for holding registers, read return and write response.
    always_comb begin
        aw_full_d    = aw_full_q;
        aw_addr_d    = aw_addr_q;
        w_full_d     = w_full_q;
        w_data_d     = w_data_q;
        rd_valid_d   = rd_valid_q;
        rd_data_d    = rd_data_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;

        if (commit) begin
            aw_full_d = 1'b0;
            w_full_d  = 1'b0;
        end
        if (aw_fire) begin
            aw_full_d = 1'b1;
            aw_addr_d = bus_addr_write_bus_data;
        end
        if (w_fire) begin
            w_full_d = 1'b1;
            w_data_d = bus_data_write_bus_data;
        end

        // The array is read before this edge's commit lands: same-edge reads see old data.
        if (ar_fire) begin
            rd_valid_d = 1'b1;
            rd_data_d  = rd_in_range ? arr_rdata : '1;
        end else if (bus_data_read_bus_ready) begin
            rd_valid_d = 1'b0;
        end

        if (commit) begin
            resp_valid_d = 1'b1;
            resp_data_d  = wr_in_range ? DATA_WIDTH'(RESP_OKAY) : DATA_WIDTH'(RESP_DECERR);
        end else if (bus_resp_write_bus_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset discarding any in-flight transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full_q    <= 1'b0;
            aw_addr_q    <= '0;
            w_full_q     <= 1'b0;
            w_data_q     <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            resp_valid_q <= 1'b0;
            resp_data_q  <= '0;
        end else begin
            aw_full_q    <= aw_full_d;
            aw_addr_q    <= aw_addr_d;
            w_full_q     <= w_full_d;
            w_data_q     <= w_data_d;
            rd_valid_q   <= rd_valid_d;
            rd_data_q    <= rd_data_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
        end
    end

endmodule

// File: tb/tb_reg_file_bus_target.sv
// Self-checking bench for reg_file_bus_target: directed scenarios followed by
// randomized traffic, all compared against a transaction-level reference model.
module tb_reg_file_bus_target;

    localparam int DW    = 8;
    localparam int AW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] ar_d;  logic ar_v, ar_r;
    logic [DW-1:0] dr_d;  logic dr_v, dr_r;
    logic [AW-1:0] aw_d;  logic aw_v, aw_r;
    logic [DW-1:0] w_d;   logic w_v, w_r;
    logic [DW-1:0] rs_d;  logic rs_v, rs_r;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    reg_file_bus_target #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .DEPTH      (DEPTH)
    ) dut (
        .clk                      (clk),
        .rst                      (rst),
        .bus_addr_read_bus_data   (ar_d),
        .bus_addr_read_bus_valid  (ar_v),
        .bus_addr_read_bus_ready  (ar_r),
        .bus_data_read_bus_data   (dr_d),
        .bus_data_read_bus_valid  (dr_v),
        .bus_data_read_bus_ready  (dr_r),
        .bus_addr_write_bus_data  (aw_d),
        .bus_addr_write_bus_valid (aw_v),
        .bus_addr_write_bus_ready (aw_r),
        .bus_data_write_bus_data  (w_d),
        .bus_data_write_bus_valid (w_v),
        .bus_data_write_bus_ready (w_r),
        .bus_resp_write_bus_data  (rs_d),
        .bus_resp_write_bus_valid (rs_v),
        .bus_resp_write_bus_ready (rs_r)
    );

    // Reference model: register contents plus the pending address, data,
    // read return and response slots, advanced once per clock edge.
    logic [7:0] m_mem [DEPTH];
    bit         m_aw_full, m_w_full, m_rd_valid, m_resp_valid;
    logic [7:0] m_aw_addr, m_w_data, m_rd_data, m_resp_data;
    bit         f_ar, f_aw, f_w;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit m_ar_rdy();
        return !rst && (!m_rd_valid || dr_r);
    endfunction

    task automatic model_edge();
        bit commit;
        f_ar   = ar_v && m_ar_rdy();
        f_aw   = aw_v && !rst && !m_aw_full;
        f_w    = w_v && !rst && !m_w_full;
        commit = !rst && m_aw_full && m_w_full && (!m_resp_valid || rs_r);
        if (rst) begin
            foreach (m_mem[i]) m_mem[i] = 8'h00;
            m_aw_full = 0; m_w_full = 0; m_rd_valid = 0; m_resp_valid = 0;
            m_rd_data = 8'h00; m_resp_data = 8'h00;
        end else begin
            if (f_ar) begin
                m_rd_data  = (ar_d < DEPTH) ? m_mem[ar_d] : 8'hFF;
                m_rd_valid = 1;
            end else if (dr_r) begin
                m_rd_valid = 0;
            end
            if (commit) begin
                if (m_aw_addr < DEPTH) m_mem[m_aw_addr] = m_w_data;
                m_resp_data  = (m_aw_addr < DEPTH) ? 8'h00 : 8'h02;
                m_resp_valid = 1;
                m_aw_full    = 0;
                m_w_full     = 0;
            end else if (rs_r) begin
                m_resp_valid = 0;
            end
            if (f_aw) begin m_aw_full = 1; m_aw_addr = aw_d; end
            if (f_w)  begin m_w_full  = 1; m_w_data  = w_d;  end
        end
    endtask

    // Compare every output against the model, then advance one clock.
    task automatic step();
        #1;
        check_eq("ar_ready",   ar_r, m_ar_rdy());
        check_eq("aw_ready",   aw_r, !rst && !m_aw_full);
        check_eq("w_ready",    w_r,  !rst && !m_w_full);
        check_eq("rd_valid",   dr_v, m_rd_valid);
        check_eq("rd_data",    dr_d, m_rd_data);
        check_eq("resp_valid", rs_v, m_resp_valid);
        check_eq("resp_data",  rs_d, m_resp_data);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        ar_v = 1; ar_d = a; dr_r = 1;
        step();
        ar_v = 0;
        check_eq({tag, "_v"}, dr_v, 1);
        check_eq(tag, dr_d, exp);
        step();
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic [7:0] code, input string tag);
        aw_v = 1; aw_d = a; w_v = 1; w_d = d; rs_r = 1;
        step();
        aw_v = 0; w_v = 0;
        check_eq({tag, "_early"}, rs_v, 0);
        step();
        check_eq({tag, "_v"}, rs_v, 1);
        check_eq({tag, "_code"}, rs_d, code);
        step();
    endtask

    function automatic logic [7:0] rand_addr();
        return ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 3));
    endfunction

    initial begin
        rst = 1; ar_v = 0; ar_d = '0; dr_r = 0; aw_v = 0; aw_d = '0;
        w_v = 0; w_d = '0; rs_r = 0;
        @(posedge clk);
        model_edge();
        @(negedge clk);

        // Reset values
        step();
        check_eq("rst_ar_ready", ar_r, 0);
        check_eq("rst_aw_ready", aw_r, 0);
        check_eq("rst_w_ready",  w_r,  0);
        rst = 0;
        #1;
        check_eq("post_ar_ready", ar_r, 1);
        check_eq("post_aw_ready", aw_r, 1);
        check_eq("post_w_ready",  w_r,  1);
        check_eq("post_rd_valid", dr_v, 0);
        check_eq("post_rs_valid", rs_v, 0);
        rd(8'd3, 8'h00, "rd3_after_reset");

        // Write then read, address and data together
        wr(8'd5, 8'hA5, 8'h00, "wr5");
        rd(8'd5, 8'hA5, "rd5");

        // Data first, address four cycles later
        w_v = 1; w_d = 8'h3C;
        step();
        w_v = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("split_w_ready", w_r, 0);
            check_eq("split_no_resp", rs_v, 0);
            step();
        end
        aw_v = 1; aw_d = 8'd9;
        step();
        aw_v = 0;
        check_eq("split_early", rs_v, 0);
        step();
        check_eq("split_v", rs_v, 1);
        check_eq("split_code", rs_d, 8'h00);
        step();
        rd(8'd9, 8'h3C, "rd9");

        // Out-of-range address
        wr(8'h20, 8'h5A, 8'h02, "wr_oor");
        rd(8'h20, 8'hFF, "rd_oor");
        rd(8'h00, 8'h00, "rd0_untouched");

        // Response backpressure across two writes
        rs_r = 0;
        aw_v = 1; aw_d = 8'd1; w_v = 1; w_d = 8'h11;
        step();
        aw_v = 0; w_v = 0;
        step();
        aw_v = 1; aw_d = 8'd4; w_v = 1; w_d = 8'h44;
        step();
        aw_v = 0; w_v = 0;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_resp_v", rs_v, 1);
            check_eq("bp_resp_code", rs_d, 8'h00);
            check_eq("bp_aw_ready", aw_r, 0);
            check_eq("bp_w_ready", w_r, 0);
            step();
        end
        rs_r = 1;
        step();
        check_eq("bp_second_v", rs_v, 1);
        check_eq("bp_second_code", rs_d, 8'h00);
        step();
        check_eq("bp_drained", rs_v, 0);
        rd(8'd1, 8'h11, "rd1");
        rd(8'd4, 8'h44, "rd4");

        // Read accepted on the commit edge returns the old value
        aw_v = 1; aw_d = 8'd2; w_v = 1; w_d = 8'h77; dr_r = 1;
        step();
        aw_v = 0; w_v = 0;
        ar_v = 1; ar_d = 8'd2;
        step();
        ar_v = 0;
        check_eq("coll_old", dr_d, 8'h00);
        step();
        rd(8'd2, 8'h77, "coll_new");

        // Reset with both holding registers full discards them
        aw_v = 1; aw_d = 8'd6; w_v = 1; w_d = 8'h66;
        step();
        aw_v = 0; w_v = 0;
        rst = 1;
        step();
        rst = 0;
        check_eq("rst_no_commit", rs_v, 0);
        w_v = 1; w_d = 8'h55;
        step();
        w_v = 0;
        step();
        check_eq("rst_aw_discarded", rs_v, 0);
        aw_v = 1; aw_d = 8'd6;
        step();
        aw_v = 0;
        step();
        check_eq("rst_new_pair_v", rs_v, 1);
        step();
        rd(8'd6, 8'h55, "rd6_after_reset");

        // Randomized traffic against the model
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            if (!ar_v || f_ar) begin ar_v = $urandom_range(0, 1); ar_d = rand_addr(); end
            if (!aw_v || f_aw) begin aw_v = $urandom_range(0, 1); aw_d = rand_addr(); end
            if (!w_v || f_w)   begin w_v  = $urandom_range(0, 1); w_d  = 8'($urandom); end
            dr_r = ($urandom_range(0, 3) != 0);
            rs_r = ($urandom_range(0, 2) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
